if_prefetch_stage: RTL and testbench
====================================

Name: if_prefetch_stage

Overview:
- Instruction-fetch stage directly upstream of the single-cycle decode/execute core.
- Drives the instruction SRAM, which has 1-cycle synchronous read latency.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to the core over a valid/ready handshake.
- Accepts branch redirects from the core, discards all wrong-path fetches, and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- DEPTH, 2, prefetch FIFO entries; legal values are 2 or more.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- inst_sram_we  output  1  tied 0.
- inst_sram_addr  output  32  fetch address, driven straight from the fetch_pc register.
- inst_sram_wdata  output  32  tied 0.
- inst_sram_rdata  input  32  SRAM read data, valid the cycle after the address was issued.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  core consumes the head this cycle.
- out_pc  output  32  pc of the head entry.
- out_inst  output  32  instruction word of the head entry.
- br_taken  input  1  redirect request, single-cycle pulse.
- br_target  input  32  redirect address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (asynchronous, resetn=0):
  - fetch_pc=RESET_PC, inflight=0, inflight_pc=0, FIFO count=0, pointers=0.
  - Outputs: out_valid=0, out_pc=0, out_inst=0, inst_sram_addr=RESET_PC.
  - Asserting reset mid-operation drops all buffered and in-flight fetches immediately.
- Definitions:
  - pop = out_valid & out_ready.
  - issue = ~br_taken & (count + inflight - pop < DEPTH).
- Issue:
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, no carry out).
  - Otherwise, with no flush: inflight<=0 and fetch_pc holds, so inst_sram_addr stays stable.
- Response: when inflight=1, the cycle's inst_sram_rdata is pushed into the FIFO tail as {inflight_pc, rdata}.
- Pop: the head is removed on pop. out_pc/out_inst are registered FIFO head contents with no combinational rdata bypass.
- Push and pop can occur in the same cycle; count is unchanged in that case.
- Latency: an address issued in cycle t appears at out_valid in cycle t+2.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Occupancy: count+inflight never exceeds DEPTH, so the FIFO cannot overflow. This is an assertion target.
- out_ready=0 stall: the FIFO fills to DEPTH, issue stops, fetch_pc freezes, and the head stays stable.
- Flush (br_taken=1):
  - A pop in the same cycle still completes; the popped entry is the branch itself.
  - count<=0, inflight<=0; any response arriving this cycle is discarded.
  - fetch_pc<={br_target[31:2],2'b00}; no issue this cycle.
  - Next cycle the target is issued, and out_valid for the target appears 2 cycles after that.
  - out_valid is 0 for the cycle after the flush and stays 0 until the target arrives.
- Back-to-back br_taken: the later target wins, with the same flush semantics each cycle.
- out_valid=0 with out_ready=1: no effect.
- Wrap: fetch_pc=32'hfffffffc issues and then becomes 32'h00000000.

Test Plan:
- Release reset, out_ready=1, SRAM model returns inst=addr^32'hA5A5A5A5 → first out_valid 2 cycles after the first issue, with out_pc=0x1c000000, then 0x1c000004, 0x1c000008 on consecutive cycles with matching inst.
- Hold out_ready=0 for 6 cycles after the first valid → exactly DEPTH entries buffered, inst_sram_addr frozen at 0x1c000008. Raise ready → pcs 0x1c000000, 0x1c000004, 0x1c000008… delivered with no gap or duplicate.
- Pulse br_taken with br_target=0x1c000100 while out_ready=1 and 2 fetches are pending → the next delivered pc is 0x1c000100. No pc in 0x1c000004–0x1c00000c appears after the flush.
- br_taken with br_target=0x1c000203 on two consecutive cycles, with the second target 0x1c000400 → only 0x1c000400 is delivered; the low bits forced to 0 are checked on the first target.
- Drive resetn low asynchronously mid-stream, between clock edges → out_valid drops immediately. After release, fetch restarts at 0x1c000000.
- Random out_ready (50%) for 1000 cycles with random branches → pcs delivered strictly sequential except at redirects, and the count+inflight ≤ DEPTH assertion never fires.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: drives a 1-cycle-latency instruction SRAM, buffers
// {pc, inst} pairs in a small FIFO and hands them to the core on valid/ready.
module if_prefetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   input  logic        br_taken,
   input  logic [31:0] br_target
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_inst_mem [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic [CW:0]   w_occ;
   logic [31:0]   w_target;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign inst_sram_we    = 1'b0;
   assign inst_sram_wdata = '0;
   assign inst_sram_addr  = r_fetch_pc;

   assign out_valid = (r_count != '0);
   assign out_pc    = r_pc_mem[r_rd_ptr];
   assign out_inst  = r_inst_mem[r_rd_ptr];

   assign w_pop    = out_valid & out_ready;
   assign w_push   = r_inflight & ~br_taken;
   // Occupancy after this cycle's pop, counting the fetch whose data lands now.
   assign w_occ    = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
   assign w_issue  = ~br_taken & (w_occ < LP_DEPTH);
   assign w_target = {br_target[31:2], br_target[1:0] & 2'b00};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_pc_mem      <= '{default: '0};
         r_inst_mem    <= '{default: '0};
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else if (br_taken) begin
         r_fetch_pc <= w_target;
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
         end else begin
            r_inflight <= 1'b0;
         end
         if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
            r_inst_mem[r_wr_ptr] <= inst_sram_rdata;
            r_wr_ptr             <= f_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_next(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   a_occupancy : assert property (@(posedge clk) disable iff (!resetn)
      (({1'b0, r_count} + (CW + 1)'(r_inflight)) <= LP_DEPTH));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed scenarios plus randomized ready/branch
// traffic, every cycle checked against a queue-based reference model.
module tb_if_prefetch_stage;

   localparam logic [31:0] RST_PC = 32'h1c000000;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] XKEY   = 32'hA5A5A5A5;

   logic        clk;
   logic        resetn;
   logic        inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        br_taken;
   logic [31:0] br_target;

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO contents as a queue of pcs, one optional in-flight pc.
   logic [31:0] m_fq[$];
   bit          m_pend;
   logic [31:0] m_pend_pc;
   logic [31:0] m_fpc;

   if_prefetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .br_taken        (br_taken),
      .br_target       (br_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM with 1-cycle read latency; content is a pure function of the address.
   always @(posedge clk) inst_sram_rdata <= inst_sram_addr ^ XKEY;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fq.delete();
      m_pend    = 1'b0;
      m_pend_pc = '0;
      m_fpc     = RST_PC;
   endtask

   task automatic model_check();
      chk("valid", 32'(out_valid), 32'(m_fq.size() > 0));
      chk("addr", inst_sram_addr, m_fpc);
      chk("sram_we", 32'(inst_sram_we), 32'd0);
      chk("sram_wdata", inst_sram_wdata, 32'd0);
      if (m_fq.size() > 0) begin
         chk("head_pc", out_pc, m_fq[0]);
         chk("head_inst", out_inst, m_fq[0] ^ XKEY);
      end
   endtask

   task automatic model_update(input bit r, input bit b, input logic [31:0] t);
      bit pop;
      int occ;
      pop = (m_fq.size() > 0) && r;
      occ = m_fq.size() + int'(m_pend) - int'(pop);
      if (b) begin
         m_fq.delete();
         m_pend = 1'b0;
         m_fpc  = t & 32'hfffffffc;
      end else begin
         if (pop) void'(m_fq.pop_front());
         if (m_pend) m_fq.push_back(m_pend_pc);
         if (occ < DEPTH) begin
            m_pend    = 1'b1;
            m_pend_pc = m_fpc;
            m_fpc     = m_fpc + 32'd4;
         end else begin
            m_pend = 1'b0;
         end
      end
   endtask

   // Called at a falling edge; leaves at the next falling edge.
   task automatic step(input bit r, input bit b, input logic [31:0] t);
      out_ready = r;
      br_taken  = b;
      br_target = t;
      #1;
      model_check();
      @(posedge clk);
      model_update(r, b, t);
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn    = 1'b0;
      out_ready = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_inst", out_inst, 32'd0);
      chk("rst_addr", inst_sram_addr, RST_PC);
      resetn = 1'b1;

      // First fetch latency and sequential stream
      step(1, 0, 0);
      step(1, 0, 0);
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_pc", out_pc, 32'h1c000000);
      chk("first_inst", out_inst, 32'h1c000000 ^ XKEY);
      step(1, 0, 0);
      chk("seq_pc1", out_pc, 32'h1c000004);
      step(1, 0, 0);
      chk("seq_pc2", out_pc, 32'h1c000008);
      chk("seq_inst2", out_inst, 32'h1c000008 ^ XKEY);

      // Stall fills the FIFO and freezes fetch, then drains without gaps
      do_reset();
      step(1, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_addr", inst_sram_addr, 32'h1c000008);
      chk("stall_head", out_pc, 32'h1c000000);
      for (int i = 0; i < 5; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_pc", out_pc, 32'h1c000000 + 32'(4 * i));
         step(1, 0, 0);
      end

      // Redirect with fetches pending
      do_reset();
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 32'h1c000100);
      chk("br_valid0", 32'(out_valid), 32'd0);
      chk("br_addr", inst_sram_addr, 32'h1c000100);
      step(1, 0, 0);
      chk("br_valid1", 32'(out_valid), 32'd0);
      step(1, 0, 0);
      chk("br_tgt_valid", 32'(out_valid), 32'd1);
      chk("br_tgt_pc", out_pc, 32'h1c000100);
      step(1, 0, 0);
      chk("br_next_pc", out_pc, 32'h1c000104);

      // Back-to-back redirects: low bits cleared, later target wins
      step(1, 1, 32'h1c000203);
      chk("bb_addr_lowbits", inst_sram_addr, 32'h1c000200);
      step(1, 1, 32'h1c000400);
      chk("bb_addr2", inst_sram_addr, 32'h1c000400);
      chk("bb_valid", 32'(out_valid), 32'd0);
      step(1, 0, 0);
      chk("bb_valid1", 32'(out_valid), 32'd0);
      step(1, 0, 0);
      chk("bb_pc", out_pc, 32'h1c000400);
      chk("bb_inst", out_inst, 32'h1c000400 ^ XKEY);

      // Address wrap at the top of the space
      step(1, 1, 32'hfffffff8);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("wrap_pc0", out_pc, 32'hfffffff8);
      step(1, 0, 0);
      chk("wrap_pc1", out_pc, 32'hfffffffc);
      step(1, 0, 0);
      chk("wrap_valid", 32'(out_valid), 32'd1);
      chk("wrap_pc2", out_pc, 32'h00000000);

      // Asynchronous reset between clock edges
      step(1, 0, 0);
      #2 resetn = 1'b0;
      #1;
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_addr", inst_sram_addr, RST_PC);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      step(1, 0, 0);
      step(1, 0, 0);
      chk("restart_pc", out_pc, 32'h1c000000);

      // Random ready and redirects
      for (int n = 0; n < 1000; n++) begin
         bit          r;
         bit          b;
         logic [31:0] t;
         r = 1'($urandom_range(0, 1));
         b = ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | ($urandom & 32'hf)) : $urandom;
         step(r, b, t);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
